pcileech_bar_rsp_arbiter: RTL

Merges read-completion streams from NUM_SRC BAR implementation blocks into one completion stream toward the TLP completer. Each BAR implementation emits one-cycle rd_rsp pulses and has no backpressure. This block buffers each source in a small FIFO, drains the FIFOs round-robin, and presents a single registered output with a valid/ready handshake. Overflows are flagged per source.

---
 rtl/pcileech_bar_arb_pkg.sv | 44 ++++
 rtl/pcileech_bar_rsp_fifo.sv | 59 +++++
 rtl/pcileech_bar_rsp_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/pcileech_bar_arb_pkg.sv
// Shared types and helpers for the BAR read-response arbiter.
// Holds the response beat layout and the round-robin pick function.
package pcileech_bar_arb_pkg;

  localparam int CTX_W   = 88;
  localparam int DATA_W  = 32;
  localparam int MAX_SRC = 8;
  localparam int IDX_W   = 3;

  typedef struct packed {
    logic [CTX_W-1:0]  ctx;
    logic [DATA_W-1:0] data;
  } bar_rsp_t;

  // Returns {found, winner}. The search starts at rr_last+1 and wraps modulo
  // num_src, so the source granted last is considered last.
  function automatic logic [IDX_W:0] rr_pick(
    input logic [MAX_SRC-1:0] nonempty,
    input logic [IDX_W-1:0]   rr_last,
    input logic [IDX_W:0]     num_src
  );
    logic             found;
    logic [IDX_W-1:0] win;
    logic [IDX_W:0]   cand;
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= MAX_SRC; k++) begin
      cand = {1'b0, rr_last} + (IDX_W+1)'(k);
      if (cand >= num_src) begin
        cand = cand - num_src;
      end else begin
        cand = cand;
      end
      if (!found && ((IDX_W+1)'(k) <= num_src) && nonempty[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        win   = cand[IDX_W-1:0];
      end else begin
        found = found;
      end
    end
    return {found, win};
  endfunction

endpackage

// File: rtl/pcileech_bar_rsp_fifo.sv
// Single-clock synchronous FIFO of bar_rsp_t beats for one BAR source.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module pcileech_bar_rsp_fifo
  import pcileech_bar_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  bar_rsp_t                   din,
  input  logic                       pop,
  output bar_rsp_t                   dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  bar_rsp_t          mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [AW:0]       count_r;
  logic              push_ok_s;
  logic              pop_ok_s;

  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == '0);
  assign count     = count_r;
  assign dout      = mem_r[rd_ptr_r];
  assign pop_ok_s  = pop && !empty;
  assign push_ok_s = push && (!full || pop_ok_s);

  // Storage write; contents need no reset because empty entries are never read.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_r + (AW+1)'(push_ok_s) - (AW+1)'(pop_ok_s);
    end
  end

endmodule

// File: rtl/pcileech_bar_rsp_arbiter.sv
// Merges NUM_SRC BAR read-response streams into one registered valid/ready
// completion stream. Each source is buffered in its own FIFO; FIFOs are
// drained round-robin. Optional macro PCILEECH_BAR_ARB_PRIO0_EN gives
// source 0 strict priority with round-robin among the remaining sources.
module pcileech_bar_rsp_arbiter
  import pcileech_bar_arb_pkg::*;
#(
  parameter int NUM_SRC    = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*CTX_W-1:0]  in_ctx,
  input  logic [NUM_SRC*DATA_W-1:0] in_data,
  input  logic [NUM_SRC-1:0]        in_valid,
  output logic [CTX_W-1:0]          out_ctx,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_SRC-1:0]        overflow,
  output logic                      busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  bar_rsp_t             din_s   [NUM_SRC];
  bar_rsp_t             head_s  [NUM_SRC];
  logic [CNT_W-1:0]     count_s [NUM_SRC];
  logic [NUM_SRC-1:0]   full_s;
  logic [NUM_SRC-1:0]   empty_s;
  logic [NUM_SRC-1:0]   pop_s;
  logic [NUM_SRC-1:0]   drop_s;
  logic [NUM_SRC-1:0]   ne_next_s;
  logic [MAX_SRC-1:0]   ne_pad_s;
  logic [IDX_W:0]       pick_s;
  logic                 found_s;
  logic [IDX_W-1:0]     win_s;
  logic                 rr_upd_s;
  logic                 load_en_s;
  logic                 grant_s;
  logic                 out_valid_next_s;
  bar_rsp_t             sel_s;

  logic [CTX_W-1:0]     out_ctx_r;
  logic [DATA_W-1:0]    out_data_r;
  logic                 out_valid_r;
  logic [NUM_SRC-1:0]   overflow_r;
  logic                 busy_r;
  logic [IDX_W-1:0]     rr_last_r;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign din_s[gi] = '{ctx: in_ctx[gi*CTX_W +: CTX_W], data: in_data[gi*DATA_W +: DATA_W]};

    pcileech_bar_rsp_fifo #(
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (in_valid[gi]),
      .din   (din_s[gi]),
      .pop   (pop_s[gi]),
      .dout  (head_s[gi]),
      .full  (full_s[gi]),
      .empty (empty_s[gi]),
      .count (count_s[gi])
    );
  end

  assign load_en_s = !out_valid_r || out_ready;
  assign found_s   = pick_s[IDX_W];
  assign win_s     = pick_s[IDX_W-1:0];
  assign grant_s   = load_en_s && found_s;

  // Winner selection among non-empty FIFOs.
  always_comb begin
    ne_pad_s = '0;
    ne_pad_s[NUM_SRC-1:0] = ~empty_s;
`ifdef PCILEECH_BAR_ARB_PRIO0_EN
    if (ne_pad_s[0]) begin
      pick_s   = {1'b1, IDX_W'(0)};
      rr_upd_s = 1'b0;
    end else begin
      pick_s   = rr_pick(ne_pad_s & ~MAX_SRC'(1), rr_last_r, (IDX_W+1)'(NUM_SRC));
      rr_upd_s = pick_s[IDX_W];
    end
`else
    pick_s   = rr_pick(ne_pad_s, rr_last_r, (IDX_W+1)'(NUM_SRC));
    rr_upd_s = pick_s[IDX_W];
`endif
  end

  // Per-source pop, drop detection, next-state occupancy and head mux.
  always_comb begin
    logic [CNT_W-1:0] cnt_next_v;
    logic             acc_v;
    cnt_next_v = '0;
    acc_v      = 1'b0;
    pop_s      = '0;
    drop_s     = '0;
    ne_next_s  = '0;
    sel_s      = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      pop_s[i]     = grant_s && (win_s == IDX_W'(i));
      acc_v        = in_valid[i] && (!full_s[i] || pop_s[i]);
      drop_s[i]    = in_valid[i] && full_s[i] && !pop_s[i];
      cnt_next_v   = count_s[i] + CNT_W'(acc_v) - CNT_W'(pop_s[i]);
      ne_next_s[i] = (cnt_next_v != '0);
      if (pop_s[i]) begin
        sel_s = head_s[i];
      end else begin
        sel_s = sel_s;
      end
    end
  end

  // Output valid follows the grant whenever the output register may load.
  always_comb begin
    if (load_en_s) begin
      out_valid_next_s = found_s;
    end else begin
      out_valid_next_s = out_valid_r;
    end
  end

  // Output register, round-robin pointer, sticky overflow and busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_ctx_r   <= '0;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      overflow_r  <= '0;
      busy_r      <= 1'b0;
      rr_last_r   <= IDX_W'(NUM_SRC - 1);
    end else begin
      if (grant_s) begin
        out_ctx_r  <= sel_s.ctx;
        out_data_r <= sel_s.data;
      end
      if (grant_s && rr_upd_s) begin
        rr_last_r <= win_s;
      end
      out_valid_r <= out_valid_next_s;
      overflow_r  <= overflow_r | drop_s;
      busy_r      <= (|ne_next_s) || out_valid_next_s;
    end
  end

  assign out_ctx   = out_ctx_r;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign overflow  = overflow_r;
  assign busy      = busy_r;

endmodule
